// File: rtl/ddr_fifo_rdgear_pkg.sv
// Shared types for the ddr_fifo read-side gearbox.
package ddr_fifo_rdgear_pkg;

  typedef enum logic [1:0] {
    RG_IDLE,
    RG_LOAD,
    RG_RUN,
    RG_DRAIN
  } ddr_rdgear_state_t;

  // Width of a slice index; at least one bit so NSLICE=1 still has a legal vector.
  function automatic int unsigned slice_idx_width(int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/ddr_fifo_rdgear_if.sv
// Control, FIFO-side and stream-side signals of the read gearbox.
// Signal names keep the gearbox's own direction prefixes (i_ into it, o_ out of it).
interface ddr_fifo_rdgear_if #(
  parameter int unsigned RWIDTH  = 32,
  parameter int unsigned OWIDTH  = 8,
  parameter int unsigned AWIDTH  = 3,
  parameter int unsigned LCWIDTH = 8
);

  // Run control
  logic               i_clr;
  logic               i_start;
  logic               i_stop;
  logic               i_loop_mode;
  logic [LCWIDTH-1:0] i_loop_cnt;
  logic [AWIDTH-1:0]  i_start_ptr;
  logic [AWIDTH-1:0]  i_stop_ptr;
  // FIFO read port
  logic [RWIDTH-1:0]  i_fifo_rdata;
  logic               i_fifo_empty_n;
  logic               o_fifo_read;
  logic               o_fifo_load_ptr;
  logic               o_fifo_loop_mode;
  logic [AWIDTH-1:0]  o_fifo_start_ptr;
  logic [AWIDTH-1:0]  o_fifo_stop_ptr;
  // Output slice stream
  logic               o_valid;
  logic [OWIDTH-1:0]  o_data;
  logic               o_last;
  logic               i_ready;
  // Status
  logic               o_busy;
  logic               o_done;

  // The gearbox itself
  modport slave (
    input  i_clr, i_start, i_stop, i_loop_mode, i_loop_cnt, i_start_ptr, i_stop_ptr,
    input  i_fifo_rdata, i_fifo_empty_n, i_ready,
    output o_fifo_read, o_fifo_load_ptr, o_fifo_loop_mode, o_fifo_start_ptr, o_fifo_stop_ptr,
    output o_valid, o_data, o_last, o_busy, o_done
  );

  // Whatever controls the gearbox, feeds it and consumes its stream
  modport master (
    output i_clr, i_start, i_stop, i_loop_mode, i_loop_cnt, i_start_ptr, i_stop_ptr,
    output i_fifo_rdata, i_fifo_empty_n, i_ready,
    input  o_fifo_read, o_fifo_load_ptr, o_fifo_loop_mode, o_fifo_start_ptr, o_fifo_stop_ptr,
    input  o_valid, o_data, o_last, o_busy, o_done
  );

endinterface

// File: rtl/ddr_fifo_rdgear.sv
// Read-side consumer of a ddr_fifo: pops RWIDTH entries and emits them as NSLICE
// OWIDTH-bit slices (slice 0 = low bits first) on a valid/ready stream. Also drives
// the FIFO loop-mode controls so a preloaded pattern can replay a set number of passes.
module ddr_fifo_rdgear
  import ddr_fifo_rdgear_pkg::*;
#(
  parameter int unsigned RWIDTH  = 32,
  parameter int unsigned OWIDTH  = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AWIDTH  = $clog2(DEPTH),
  parameter int unsigned LCWIDTH = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  ddr_fifo_rdgear_if.slave bus
);

  localparam int unsigned NSLICE = RWIDTH / OWIDTH;
  localparam int unsigned SWIDTH = slice_idx_width(NSLICE);
  localparam logic [SWIDTH-1:0] LastSlice = SWIDTH'(NSLICE - 1);
  localparam logic [AWIDTH-1:0] LastAddr  = AWIDTH'(DEPTH - 1);
  localparam logic [LCWIDTH-1:0] OnePass  = LCWIDTH'(1);

  if (RWIDTH % OWIDTH != 0) begin : g_bad_width
    $error("ddr_fifo_rdgear: RWIDTH must be an integer multiple of OWIDTH");
  end

  ddr_rdgear_state_t  state_q, state_d;
  logic [RWIDTH-1:0]  hold_q, hold_d;
  logic               valid_q, valid_d;
  logic [SWIDTH-1:0]  slice_q, slice_d;
  logic [AWIDTH-1:0]  ptr_q, ptr_d;
  logic [LCWIDTH-1:0] passes_q, passes_d;
  logic [LCWIDTH-1:0] cnt_q, cnt_d;
  logic               loop_q, loop_d;
  logic [AWIDTH-1:0]  start_q, start_d;
  logic [AWIDTH-1:0]  stop_q, stop_d;
  logic               done_q, done_d;

  logic accept;
  logic last_acc;
  logic can_pop;
  logic pop;

  // Next-state: FSM, slice sequencing, pop decision and loop/pass tracking
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    slice_d  = slice_q;
    ptr_d    = ptr_q;
    passes_d = passes_q;
    cnt_d    = cnt_q;
    loop_d   = loop_q;
    start_d  = start_q;
    stop_d   = stop_q;
    done_d   = 1'b0;
    pop      = 1'b0;

    accept   = valid_q & bus.i_ready;
    last_acc = accept & (slice_q == LastSlice);
    // In loop mode the FIFO replays stored entries, so emptiness does not gate pops.
    can_pop  = loop_q | bus.i_fifo_empty_n;

    if (accept) begin
      if (slice_q == LastSlice) begin
        valid_d = 1'b0;
        slice_d = '0;
      end else begin
        slice_d = slice_q + 1'b1;
      end
    end

    unique case (state_q)
      RG_IDLE: begin
        if (bus.i_start) begin
          loop_d  = bus.i_loop_mode;
          cnt_d   = bus.i_loop_cnt;
          start_d = bus.i_start_ptr;
          stop_d  = bus.i_stop_ptr;
          state_d = bus.i_loop_mode ? RG_LOAD : RG_RUN;
        end
      end
      RG_LOAD: begin
        ptr_d    = start_q;
        passes_d = cnt_q;
        state_d  = RG_RUN;
      end
      RG_RUN: begin
        if (bus.i_stop) begin
          // Stop wins over a pop in the same cycle: the held word finishes, nothing new.
          state_d = RG_DRAIN;
        end else if (can_pop && (!valid_q || last_acc)) begin
          pop     = 1'b1;
          hold_d  = bus.i_fifo_rdata;
          valid_d = 1'b1;
          slice_d = '0;
          if (loop_q) begin
            if (ptr_q == stop_q) begin
              ptr_d    = start_q;
              passes_d = (passes_q == '0) ? '0 : passes_q - 1'b1;
              if (passes_q == OnePass) begin
                state_d = RG_DRAIN;
              end
            end else begin
              ptr_d = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;
            end
          end
        end
      end
      RG_DRAIN: begin
        if (!valid_q || last_acc) begin
          state_d = RG_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = RG_IDLE;
    endcase

    // Synchronous clear mirrors reset one cycle later and overrides everything above.
    if (bus.i_clr) begin
      state_d  = RG_IDLE;
      hold_d   = '0;
      valid_d  = 1'b0;
      slice_d  = '0;
      ptr_d    = '0;
      passes_d = '0;
      cnt_d    = '0;
      loop_d   = 1'b0;
      start_d  = '0;
      stop_d   = '0;
      done_d   = 1'b0;
      pop      = 1'b0;
    end
  end

  // State registers, asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RG_IDLE;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      slice_q  <= '0;
      ptr_q    <= '0;
      passes_q <= '0;
      cnt_q    <= '0;
      loop_q   <= 1'b0;
      start_q  <= '0;
      stop_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      slice_q  <= slice_d;
      ptr_q    <= ptr_d;
      passes_q <= passes_d;
      cnt_q    <= cnt_d;
      loop_q   <= loop_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_fifo_read      = pop;
  assign bus.o_fifo_load_ptr  = (state_q == RG_LOAD);
  assign bus.o_fifo_loop_mode = loop_q;
  assign bus.o_fifo_start_ptr = start_q;
  assign bus.o_fifo_stop_ptr  = stop_q;
  assign bus.o_valid          = valid_q;
  assign bus.o_data           = hold_q[int'(slice_q) * OWIDTH +: OWIDTH];
  assign bus.o_last           = valid_q & (slice_q == LastSlice);
  assign bus.o_busy           = (state_q != RG_IDLE);
  assign bus.o_done           = done_q;

endmodule
